// File: rtl/wii_cam_pkg.sv
// Shared constants and types for the IR camera extended-mode report decoder.
// Contents: report geometry, the "no blob" coordinate, FSM state constants,
// and a helper that maps a byte position within a report to its role.
package wii_cam_pkg;

  localparam int unsigned FRAME_BYTES = 13;
  localparam int unsigned OBJ_COUNT   = 4;
  localparam logic [9:0]  NO_BLOB     = 10'd1023;

  // Decoder states
  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  typedef enum logic [1:0] {
    RoleXlo  = 2'd0,
    RoleYlo  = 2'd1,
    RoleS    = 2'd2,
    RoleNone = 2'd3
  } byte_role_e;

  // Position is the index of the byte within the report (header = 0).
  function automatic byte_role_e byte_role(input logic [3:0] pos);
    byte_role_e role;
    case (pos)
      4'd1, 4'd4, 4'd7, 4'd10: role = RoleXlo;
      4'd2, 4'd5, 4'd8, 4'd11: role = RoleYlo;
      4'd3, 4'd6, 4'd9, 4'd12: role = RoleS;
      default:                 role = RoleNone;
    endcase
    return role;
  endfunction

endpackage

// File: rtl/wii_obj_unpack.sv
// Combinational unpacker for one camera object (Xlo, Ylo, S bytes).
// Ports:
//   xlo_i, ylo_i, s_i : raw object bytes
//   x_o, y_o          : 10-bit coordinates, hi bits taken from S
//   size_o            : blob size S[3:0]
//   visible_o         : object present (not the all-0xFF empty slot)
// Build option: WII_SIZE_FILTER_EN also rejects objects smaller than MIN_SIZE.
module wii_obj_unpack
`ifdef WII_SIZE_FILTER_EN
#(
  parameter int unsigned MIN_SIZE = 2
)
`endif
(
  input  logic [7:0] xlo_i,
  input  logic [7:0] ylo_i,
  input  logic [7:0] s_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic [3:0] size_o,
  output logic       visible_o
);

  logic empty_slot;

  assign x_o        = {s_i[5:4], xlo_i};
  assign y_o        = {s_i[7:6], ylo_i};
  assign size_o     = s_i[3:0];
  assign empty_slot = (xlo_i == 8'hFF) && (ylo_i == 8'hFF) && (s_i == 8'hFF);

`ifdef WII_SIZE_FILTER_EN
  assign visible_o = !empty_slot && (32'(size_o) >= MIN_SIZE);
`else
  assign visible_o = !empty_slot;
`endif

endmodule

// File: rtl/wii_cam_decoder.sv
// Byte-stream decoder for the IR camera's 13-byte extended-mode report.
// Selects the lowest-index visible object and counts visible objects.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   byte_valid         : byte_data valid (always accepted)
//   byte_data          : report byte
//   frame_start        : qualifies byte_valid as the header of a new report
//   x_out, y_out       : selected blob coordinates (1023/1023 = no blob)
//   size_out           : selected blob size
//   blob_count         : visible objects in last complete frame
//   frame_valid        : one-cycle pulse, outputs refreshed from a complete frame
//   frame_err          : one-cycle pulse, frame aborted by an early frame_start
// Build option: WII_SIZE_FILTER_EN enables the MIN_SIZE blob size filter.
module wii_cam_decoder
  import wii_cam_pkg::*;
#(
  parameter int unsigned MIN_SIZE = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       frame_start,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic [3:0] size_out,
  output logic [2:0] blob_count,
  output logic       frame_valid,
  output logic       frame_err
);

  if (MIN_SIZE > 15) begin : g_bad_min_size
    $error("MIN_SIZE must be in 0..15");
  end

  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] xlo_q, xlo_d, ylo_q, ylo_d;
  logic [9:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [3:0] cand_size_q, cand_size_d;
  logic       found_q, found_d;
  logic [2:0] count_q, count_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [3:0] size_q, size_d;
  logic [2:0] blob_count_q, blob_count_d;
  logic       frame_valid_q, frame_valid_d;
  logic       frame_err_q, frame_err_d;

  logic       accept_hdr, accept_obj, obj_hit, take_new, last_byte;
  byte_role_e role;
  logic [9:0] obj_x, obj_y;
  logic [3:0] obj_size;
  logic       obj_visible;

  // The S byte is unpacked straight off the bus so visibility is known the cycle it arrives.
  wii_obj_unpack
`ifdef WII_SIZE_FILTER_EN
  #(
    .MIN_SIZE(MIN_SIZE)
  )
`endif
  u_unpack (
    .xlo_i    (xlo_q),
    .ylo_i    (ylo_q),
    .s_i      (byte_data),
    .x_o      (obj_x),
    .y_o      (obj_y),
    .size_o   (obj_size),
    .visible_o(obj_visible)
  );

  assign accept_hdr = byte_valid && frame_start;
  assign accept_obj = byte_valid && !frame_start && (state_q == COLLECT);
  assign role       = byte_role(cnt_q);
  assign obj_hit    = accept_obj && (role == RoleS) && obj_visible;
  assign take_new   = obj_hit && !found_q;
  assign last_byte  = accept_obj && (cnt_q == 4'(FRAME_BYTES - 1));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    xlo_d         = xlo_q;
    ylo_d         = ylo_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    cand_size_d   = cand_size_q;
    found_d       = found_q;
    count_d       = count_q;
    x_d           = x_q;
    y_d           = y_q;
    size_d        = size_q;
    blob_count_d  = blob_count_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (accept_hdr) begin
      // A header while collecting restarts the frame; the partial one is dropped.
      frame_err_d = (state_q == COLLECT);
      state_d     = COLLECT;
      cnt_d       = 4'd1;
      found_d     = 1'b0;
      count_d     = 3'd0;
      cand_x_d    = NO_BLOB;
      cand_y_d    = NO_BLOB;
      cand_size_d = 4'd0;
    end else if (accept_obj) begin
      cnt_d = cnt_q + 4'd1;
      case (role)
        RoleXlo: xlo_d = byte_data;
        RoleYlo: ylo_d = byte_data;
        default: ;
      endcase
      if (obj_hit) begin
        count_d = count_q + 3'd1;
      end
      if (take_new) begin
        found_d     = 1'b1;
        cand_x_d    = obj_x;
        cand_y_d    = obj_y;
        cand_size_d = obj_size;
      end
      // Outputs are loaded from the next-state candidates so the final object counts too.
      if (last_byte) begin
        state_d       = IDLE;
        cnt_d         = 4'd0;
        frame_valid_d = 1'b1;
        x_d           = cand_x_d;
        y_d           = cand_y_d;
        size_d        = cand_size_d;
        blob_count_d  = count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      xlo_q         <= 8'd0;
      ylo_q         <= 8'd0;
      cand_x_q      <= NO_BLOB;
      cand_y_q      <= NO_BLOB;
      cand_size_q   <= 4'd0;
      found_q       <= 1'b0;
      count_q       <= 3'd0;
      x_q           <= NO_BLOB;
      y_q           <= NO_BLOB;
      size_q        <= 4'd0;
      blob_count_q  <= 3'd0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      xlo_q         <= xlo_d;
      ylo_q         <= ylo_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      cand_size_q   <= cand_size_d;
      found_q       <= found_d;
      count_q       <= count_d;
      x_q           <= x_d;
      y_q           <= y_d;
      size_q        <= size_d;
      blob_count_q  <= blob_count_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign x_out       = x_q;
  assign y_out       = y_q;
  assign size_out    = size_q;
  assign blob_count  = blob_count_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_wii_cam_decoder.sv
// Self-checking bench for wii_cam_decoder: directed report frames plus
// randomized frames with random byte gaps, aborts and mid-frame reset,
// compared against a behavioural model of the report format.
module tb_wii_cam_decoder;

`ifdef WII_SIZE_FILTER_EN
  localparam int unsigned MinSz = 4;
`else
  localparam int unsigned MinSz = 2;
`endif

  typedef logic [7:0] frame_t [12];

  logic       clk = 1'b0;
  logic       reset_n;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_start;
  logic [9:0] x_out, y_out;
  logic [3:0] size_out;
  logic [2:0] blob_count;
  logic       frame_valid, frame_err;

  int total = 0;
  int bad   = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int exp_x = 1023, exp_y = 1023, exp_sz = 0, exp_cnt = 0;

  always #5 clk = ~clk;

  wii_cam_decoder #(
    .MIN_SIZE(MinSz)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_start(frame_start),
    .x_out      (x_out),
    .y_out      (y_out),
    .size_out   (size_out),
    .blob_count (blob_count),
    .frame_valid(frame_valid),
    .frame_err  (frame_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor: counts pulses and checks they never coincide.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
    if (frame_valid === 1'b1 || frame_err === 1'b1)
      check_val("pulse_excl", {31'd0, frame_valid & frame_err}, 0);
  end

  // Reference: first visible object wins, count visible ones.
  function automatic void ref_model(input frame_t b, output int x, output int y,
                                    output int sz, output int cnt);
    x = 1023; y = 1023; sz = 0; cnt = 0;
    for (int k = 0; k < 4; k++) begin
      int xl, yl, s;
      bit vis;
      xl  = b[3*k];
      yl  = b[3*k+1];
      s   = b[3*k+2];
      vis = !(xl == 255 && yl == 255 && s == 255);
`ifdef WII_SIZE_FILTER_EN
      if (s % 16 < MinSz) vis = 0;
`endif
      if (vis) begin
        if (cnt == 0) begin
          x  = ((s / 16) % 4) * 256 + xl;
          y  = (s / 64) * 256 + yl;
          sz = s % 16;
        end
        cnt++;
      end
    end
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic fs);
    @(negedge clk);
    byte_valid  = v;
    byte_data   = d;
    frame_start = fs;
  endtask

  task automatic gaps(input int gap_max);
    int n;
    n = $urandom_range(0, gap_max);
    for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom), 1'($urandom));
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, "_x"}, 32'(x_out), exp_x);
    check_val({tag, "_y"}, 32'(y_out), exp_y);
    check_val({tag, "_size"}, 32'(size_out), exp_sz);
    check_val({tag, "_count"}, 32'(blob_count), exp_cnt);
  endtask

  // Header plus n object bytes from f, no completion.
  task automatic send_partial(input frame_t f, input int n, input int gap_max);
    drive(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < n; i++) begin
      gaps(gap_max);
      drive(1'b1, f[i], 1'b0);
    end
  endtask

  task automatic send_frame(input string tag, input frame_t f, input int gap_max);
    int fv0;
    fv0 = fv_cnt;
    drive(1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 12; i++) begin
      gaps(gap_max);
      if (i == 11) begin
        check_outputs({tag, "_hold"});
        check_val({tag, "_nopulse"}, fv_cnt - fv0, 0);
      end
      drive(1'b1, f[i], 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0);
    check_val({tag, "_fv"}, {31'd0, frame_valid}, 1);
    ref_model(f, exp_x, exp_y, exp_sz, exp_cnt);
    check_outputs(tag);
    drive(1'b0, 8'h00, 1'b0);
    check_val({tag, "_fv_off"}, {31'd0, frame_valid}, 0);
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < 4; k++) begin
      bit empty;
      empty = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 3; j++) f[3*k+j] = empty ? 8'hFF : 8'($urandom);
    end
    return f;
  endfunction

  initial begin
    frame_t f2, fe, f4;
    int fe0, fv0;

    f2 = '{8'h34, 8'h12, 8'h5A, 8'hFF, 8'hFF, 8'hFF,
           8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    foreach (fe[i]) fe[i] = 8'hFF;
    f4 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
           8'h00, 8'h00, 8'hF3, 8'h10, 8'h20, 8'h05};

    // Reset with random bus activity
    reset_n = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h34; frame_start = 1'b1;
    drive(1'b1, 8'h12, 1'b1);
    drive(1'b1, 8'h5A, 1'b0);
    reset_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    check_outputs("reset");
    check_val("reset_fv", {31'd0, frame_valid}, 0);
    check_val("reset_fe", {31'd0, frame_err}, 0);

    // Stray bytes in IDLE are discarded
    fv0 = fv_cnt;
    for (int i = 0; i < 13; i++) drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check_val("idle_discard", fv_cnt - fv0, 0);

    send_frame("t2", f2, 0);
    check_val("t2_const_x", 32'(x_out), 308);
    check_val("t2_const_y", 32'(y_out), 274);
    check_val("t2_const_size", 32'(size_out), 10);

    send_frame("t3", fe, 0);
    check_val("t3_const_x", 32'(x_out), 1023);
    check_val("t3_const_count", 32'(blob_count), 0);

    send_frame("t4", f4, 0);
`ifdef WII_SIZE_FILTER_EN
    check_val("t4_const_x", 32'(x_out), 16);
    check_val("t4_const_count", 32'(blob_count), 1);
`else
    check_val("t4_const_x", 32'(x_out), 768);
    check_val("t4_const_count", 32'(blob_count), 2);
`endif

    // Abort after 5 bytes, then a full frame with gaps
    fe0 = fe_cnt;
    send_partial(fe, 4, 2);
    send_frame("t5", f2, 3);
    check_val("t5_err_once", fe_cnt - fe0, 1);
    check_val("t5_const_x", 32'(x_out), 308);

    // Reset mid-frame at byte 7 with a byte on the bus
    send_partial(f2, 6, 1);
    @(negedge clk);
    reset_n = 1'b0; byte_valid = 1'b1; byte_data = 8'h00; frame_start = 1'b1;
    @(negedge clk);
    reset_n = 1'b1; byte_valid = 1'b0; frame_start = 1'b0;
    exp_x = 1023; exp_y = 1023; exp_sz = 0; exp_cnt = 0;
    check_outputs("t6_reset");
    fv0 = fv_cnt;
    for (int i = 0; i < 6; i++) drive(1'b1, 8'h01, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check_val("t6_no_resume", fv_cnt - fv0, 0);
    send_frame("t6", f4, 2);

    // Randomized frames, some preceded by an aborted partial frame
    for (int n = 0; n < 40; n++) begin
      frame_t fr;
      fr  = rand_frame();
      fe0 = fe_cnt;
      if ($urandom_range(0, 3) == 0) begin
        send_partial(rand_frame(), $urandom_range(0, 11), 2);
        send_frame("rnd_abort", fr, 3);
        check_val("rnd_err_once", fe_cnt - fe0, 1);
      end else begin
        send_frame("rnd", fr, 3);
        check_val("rnd_no_err", fe_cnt - fe0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
